// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: rebuilds x/y and a video window from hsync/vsync,
// measures line and frame periods and tracks lock to the expected mode.
module vga_sync_decoder #(
   parameter int HD           = 640,
   parameter int HMAX         = 799,
   parameter int H_SYNC_START = 656,
   parameter int VD           = 480,
   parameter int VMAX         = 524,
   parameter int V_SYNC_START = 513,
   parameter int LOCK_FRAMES  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       p_tick,
   input  logic       hsync_in,
   input  logic       vsync_in,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       video_on,
   output logic       locked,
   output logic       frame_start,
   output logic       sync_err,
   output logic [9:0] h_total,
   output logic [9:0] v_total
);

   localparam logic [1:0]  ST_SEARCH = 2'd0;
   localparam logic [1:0]  ST_CHECK  = 2'd1;
   localparam logic [1:0]  ST_LOCKED = 2'd2;

   localparam logic [9:0]  SAT       = 10'd1023;
   localparam logic [9:0]  X_MAX     = 10'(HMAX);
   localparam logic [9:0]  X_LOAD    = 10'(H_SYNC_START);
   localparam logic [9:0]  Y_MAX     = 10'(VMAX);
   localparam logic [9:0]  Y_LOAD    = 10'(V_SYNC_START);
   localparam logic [9:0]  X_ACT     = 10'(HD);
   localparam logic [9:0]  Y_ACT     = 10'(VD);
   localparam logic [10:0] LINE_LEN  = 11'(HMAX + 1);
   localparam logic [9:0]  FRAME_LEN = 10'(VMAX + 1);
   localparam logic [7:0]  GOOD_NEED = 8'(LOCK_FRAMES);

   logic       hs_d_q, hs_d_d;
   logic       vs_d_q, vs_d_d;
   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic [9:0] h_meas_q, h_meas_d;
   logic [9:0] v_meas_q, v_meas_d;
   logic [9:0] h_total_q, h_total_d;
   logic [9:0] v_total_q, v_total_d;
   logic [1:0] state_q, state_d;
   logic [7:0] good_cnt_q, good_cnt_d;
   logic       locked_q, locked_d;
   logic       line_bad_q, line_bad_d;
   logic       frame_start_q, frame_start_d;
   logic       sync_err_q, sync_err_d;

   logic        hs_rise;
   logic        vs_rise;
   logic        x_wrap;
   logic [10:0] h_inc;
   logic        line_bad;
   logic        h_tmo;
   logic        v_tmo;
   logic        any_err;
   logic        frame_good;

   // Sync edge detection and the error/quality events derived from it
   always_comb begin
      hs_rise    = p_tick & hsync_in & ~hs_d_q;
      vs_rise    = p_tick & vsync_in & ~vs_d_q;
      x_wrap     = p_tick & ~hs_rise & (x_q == X_MAX);
      h_inc      = {1'b0, h_meas_q} + 11'd1;
      line_bad   = hs_rise & (h_inc != LINE_LEN);
      h_tmo      = p_tick & ~hs_rise & (h_meas_q == SAT - 10'd1);
      v_tmo      = hs_rise & ~vs_rise & (v_meas_q == SAT - 10'd1);
      any_err    = line_bad | h_tmo | v_tmo;
      frame_good = (v_meas_q == FRAME_LEN) & ~line_bad_q & ~line_bad;
   end

   // Free-running coordinates, re-anchored by each sync rise
   always_comb begin
      hs_d_d = hs_d_q;
      vs_d_d = vs_d_q;
      x_d    = x_q;
      y_d    = y_q;
      if (p_tick) begin
         hs_d_d = hsync_in;
         vs_d_d = vsync_in;
         if (hs_rise)
            x_d = X_LOAD;
         else if (x_q == X_MAX)
            x_d = '0;
         else
            x_d = x_q + 10'd1;
      end
      if (vs_rise)
         y_d = Y_LOAD;
      else if (x_wrap)
         y_d = (y_q == Y_MAX) ? '0 : y_q + 10'd1;
   end

   // Saturating line/frame period measurement
   always_comb begin
      h_meas_d   = h_meas_q;
      v_meas_d   = v_meas_q;
      h_total_d  = h_total_q;
      v_total_d  = v_total_q;
      line_bad_d = line_bad_q;
      if (hs_rise) begin
         h_total_d = (h_meas_q == SAT) ? SAT : h_inc[9:0];
         h_meas_d  = '0;
      end else if (p_tick && h_meas_q != SAT) begin
         h_meas_d  = h_meas_q + 10'd1;
      end
      if (vs_rise) begin
         v_total_d  = v_meas_q;
         v_meas_d   = '0;
         line_bad_d = 1'b0;
      end else begin
         if (hs_rise && v_meas_q != SAT)
            v_meas_d = v_meas_q + 10'd1;
         if (line_bad)
            line_bad_d = 1'b1;
      end
   end

   // Lock tracking and the one-clk status pulses
   always_comb begin
      state_d    = state_q;
      good_cnt_d = good_cnt_q;
      locked_d   = locked_q;
      sync_err_d = 1'b0;
      case (state_q)
         ST_SEARCH: begin
            if (vs_rise) begin
               state_d    = ST_CHECK;
               good_cnt_d = '0;
            end
         end
         ST_CHECK: begin
            if (any_err) begin
               sync_err_d = 1'b1;
               state_d    = ST_SEARCH;
            end else if (vs_rise) begin
               if (frame_good) begin
                  good_cnt_d = good_cnt_q + 8'd1;
                  if (good_cnt_q + 8'd1 == GOOD_NEED) begin
                     state_d  = ST_LOCKED;
                     locked_d = 1'b1;
                  end
               end else begin
                  sync_err_d = 1'b1;
                  good_cnt_d = '0;
               end
            end
         end
         ST_LOCKED: begin
            if (any_err | (vs_rise & ~frame_good)) begin
               sync_err_d = 1'b1;
               locked_d   = 1'b0;
               state_d    = ST_SEARCH;
            end
         end
         default: begin
            state_d  = ST_SEARCH;
            locked_d = 1'b0;
         end
      endcase
      frame_start_d = p_tick & locked_d & (x_d == '0) & (y_d == '0);
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hs_d_q        <= 1'b0;
         vs_d_q        <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         h_meas_q      <= '0;
         v_meas_q      <= '0;
         h_total_q     <= '0;
         v_total_q     <= '0;
         state_q       <= ST_SEARCH;
         good_cnt_q    <= '0;
         locked_q      <= 1'b0;
         line_bad_q    <= 1'b0;
         frame_start_q <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         hs_d_q        <= hs_d_d;
         vs_d_q        <= vs_d_d;
         x_q           <= x_d;
         y_q           <= y_d;
         h_meas_q      <= h_meas_d;
         v_meas_q      <= v_meas_d;
         h_total_q     <= h_total_d;
         v_total_q     <= v_total_d;
         state_q       <= state_d;
         good_cnt_q    <= good_cnt_d;
         locked_q      <= locked_d;
         line_bad_q    <= line_bad_d;
         frame_start_q <= frame_start_d;
         sync_err_q    <= sync_err_d;
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign locked      = locked_q;
   assign frame_start = frame_start_q;
   assign sync_err    = sync_err_q;
   assign h_total     = h_total_q;
   assign v_total     = v_total_q;
   assign video_on    = locked_q & (x_q < X_ACT) & (y_q < Y_ACT);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a reduced-size mode drives a sync generator,
// an event-level model predicts every output after each clock.
module tb_vga_sync_decoder;

   localparam int HD   = 16;
   localparam int HMAX = 23;
   localparam int HSS  = 18;
   localparam int HSW  = 4;
   localparam int VD   = 8;
   localparam int VMAX = 11;
   localparam int VSS  = 9;
   localparam int LF   = 2;
   localparam int HT   = HMAX + 1;
   localparam int VT   = VMAX + 1;
   localparam int FCLK = HT * VT * 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       p_tick = 1'b0;
   logic       hsync_in = 1'b0;
   logic       vsync_in = 1'b0;
   logic [9:0] x, y, h_total, v_total;
   logic       video_on, locked, frame_start, sync_err;

   int errors = 0;
   int checks = 0;

   int gx = 0, gy = 0, c_gx = 0, c_gy = 0;
   bit g_kill = 0, g_skip = 0, phase = 0, rnd_pt = 0;

   int m_t, m_hanc, m_xbase, m_hcnt, m_vanc;
   int m_x, m_y, m_htot, m_vtot, m_mode, m_good;
   bit m_hs_prev, m_vs_prev, m_badline, m_fs, m_err, m_vr, m_hr;

   logic [43:0] act_v, exp_v;

   assign act_v = {x, y, video_on, locked, frame_start, sync_err,
                   h_total, v_total};
   assign exp_v = {m_x[9:0], m_y[9:0],
                   (m_mode == 2) && (m_x < HD) && (m_y < VD),
                   m_mode == 2, m_fs, m_err,
                   m_htot[9:0], m_vtot[9:0]};

   vga_sync_decoder #(
      .HD(HD), .HMAX(HMAX), .H_SYNC_START(HSS),
      .VD(VD), .VMAX(VMAX), .V_SYNC_START(VSS),
      .LOCK_FRAMES(LF)
   ) dut (
      .clk(clk), .reset(reset), .p_tick(p_tick),
      .hsync_in(hsync_in), .vsync_in(vsync_in),
      .x(x), .y(y), .video_on(video_on), .locked(locked),
      .frame_start(frame_start), .sync_err(sync_err),
      .h_total(h_total), .v_total(v_total)
   );

   always #5 clk = ~clk;

   function automatic int sat(input int v);
      return (v > 1023) ? 1023 : v;
   endfunction

   task automatic model_reset();
      m_t = 0; m_hanc = 0; m_xbase = 0; m_hcnt = 0; m_vanc = 0;
      m_x = 0; m_y = 0; m_htot = 0; m_vtot = 0; m_mode = 0; m_good = 0;
      m_hs_prev = 0; m_vs_prev = 0; m_badline = 0;
      m_fs = 0; m_err = 0; m_vr = 0; m_hr = 0;
   endtask

   // Period/phase model: x is the tick distance from the last hsync anchor,
   // periods are differences of tick / line-event counts.
   task automatic model_tick(input bit hs, input bit vs);
      int hm, vm, px;
      bit bad, hto, vto, err, fgood;
      hm = sat(m_t - m_hanc);
      vm = sat(m_hcnt - m_vanc);
      px = m_x;
      m_hr = hs && !m_hs_prev;
      m_vr = vs && !m_vs_prev;
      m_hs_prev = hs;
      m_vs_prev = vs;
      m_t++;
      bad = 0; hto = 0; vto = 0; fgood = 0;
      if (m_hr) begin
         m_htot = sat(hm + 1);
         bad = (hm + 1 != HT);
         m_hanc = m_t;
         m_xbase = HSS;
         m_hcnt++;
      end else if (m_t - m_hanc == 1023) begin
         hto = 1;
      end
      if (m_vr)
         m_y = VSS;
      else if (!m_hr && px == HMAX)
         m_y = (m_y == VMAX) ? 0 : m_y + 1;
      if (m_vr) begin
         m_vtot = vm;
         fgood = (vm == VT) && !m_badline && !bad;
         m_vanc = m_hcnt;
         m_badline = 0;
      end else begin
         if (m_hr && m_hcnt - m_vanc == 1023) vto = 1;
         if (bad) m_badline = 1;
      end
      err = bad || hto || vto;
      m_err = 0;
      case (m_mode)
         0: if (m_vr) begin m_mode = 1; m_good = 0; end
         1: begin
            if (err) begin
               m_err = 1; m_mode = 0;
            end else if (m_vr) begin
               if (fgood) begin
                  m_good++;
                  if (m_good == LF) m_mode = 2;
               end else begin
                  m_err = 1; m_good = 0;
               end
            end
         end
         default: if (err || (m_vr && !fgood)) begin
            m_err = 1; m_mode = 0;
         end
      endcase
      m_x = (m_xbase + m_t - m_hanc) % HT;
      m_fs = (m_mode == 2) && m_x == 0 && m_y == 0;
   endtask

   task automatic drive();
      hsync_in = !g_kill && gx >= HSS && gx < HSS + HSW;
      vsync_in = !g_kill && gy >= VSS && gy < VSS + 2;
   endtask

   task automatic gen_adv();
      if (g_skip && gx == 2) begin
         gx = 4; g_skip = 0;
      end else if (gx == HMAX) begin
         gx = 0;
         gy = (gy == VMAX) ? 0 : gy + 1;
      end else begin
         gx++;
      end
   endtask

   task automatic step(input bit pt);
      p_tick = pt;
      if (reset) model_reset();
      else if (pt) model_tick(hsync_in, vsync_in);
      else begin m_fs = 0; m_err = 0; m_vr = 0; m_hr = 0; end
      @(posedge clk);
      #1;
      if (pt) begin
         c_gx = gx; c_gy = gy;
         gen_adv();
      end
      drive();
   endtask

   task automatic clk1();
      if (rnd_pt) step(1'($urandom_range(0, 1)));
      else begin step(phase); phase = ~phase; end
   endtask

   task automatic test_reset();
      reset = 1;
      for (int i = 0; i < 3; i++) step(0);
      checks++;
      if (act_v !== 44'd0) begin
         errors++;
         $display("FAIL reset_idle dut=%h want=0", act_v);
      end
      step(1);
      checks++;
      if (act_v !== exp_v || act_v !== 44'd0) begin
         errors++;
         $display("FAIL reset_tick dut=%h want=0", act_v);
      end
   endtask

   task automatic test_lock();
      int vr_cnt, tk, last, n;
      gx = 0; gy = 0; drive();
      reset = 0;
      vr_cnt = 0;
      for (int i = 0; i < 8 * FCLK && locked !== 1'b1; i++) begin
         clk1();
         if (m_vr) vr_cnt++;
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL lock_trace dut=%h model=%h", act_v, exp_v);
         end
      end
      checks++;
      if (locked !== 1'b1 || vr_cnt != 3) begin
         errors++;
         $display("FAIL lock_rise locked=%b rises=%0d want 1/3", locked, vr_cnt);
      end
      checks++;
      if (h_total !== 10'(HT) || v_total !== 10'(VT)) begin
         errors++;
         $display("FAIL totals h=%0d v=%0d want %0d/%0d", h_total, v_total, HT, VT);
      end
      tk = 0; last = -1; n = 0;
      for (int i = 0; i < 3 * FCLK + 4; i++) begin
         clk1();
         if (p_tick) tk++;
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL fs_trace dut=%h model=%h", act_v, exp_v);
         end
         if (frame_start === 1'b1) begin
            if (last >= 0) begin
               checks++;
               if (tk - last != HT * VT) begin
                  errors++;
                  $display("FAIL fs_period got=%0d want=%0d", tk - last, HT * VT);
               end
            end
            last = tk; n++;
         end
      end
      checks++;
      if (n < 3) begin
         errors++;
         $display("FAIL fs_count got=%0d want>=3", n);
      end
   endtask

   task automatic test_align();
      int ld;
      rnd_pt = 1; ld = 0;
      for (int i = 0; i < 2 * FCLK; i++) begin
         clk1();
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL align_trace dut=%h model=%h", act_v, exp_v);
         end
         if (p_tick) begin
            if (c_gx == HSS) ld++;
            checks++;
            if (x !== 10'(c_gx) || y !== 10'(c_gy) ||
                video_on !== ((c_gx < HD) && (c_gy < VD))) begin
               errors++;
               $display("FAIL align x=%0d y=%0d vo=%b want %0d/%0d", x, y, video_on, c_gx, c_gy);
            end
         end
      end
      rnd_pt = 0;
      checks++;
      if (ld == 0 || locked !== 1'b1) begin
         errors++;
         $display("FAIL align_cover loads=%0d locked=%b", ld, locked);
      end
   endtask

   task automatic test_short_line();
      int vr_cnt;
      bit seen;
      int pre;
      pre = $urandom_range(0, 2 * FCLK / VT);
      for (int i = 0; i < pre; i++) clk1();
      g_skip = 1; seen = 0;
      for (int i = 0; i < 4 * HT + 8 && !seen; i++) begin
         clk1();
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL short_trace dut=%h model=%h", act_v, exp_v);
         end
         if (sync_err === 1'b1) seen = 1;
      end
      checks++;
      if (!seen || c_gx != HSS || locked !== 1'b0 || video_on !== 1'b0) begin
         errors++;
         $display("FAIL short_err seen=%0d gx=%0d locked=%b vo=%b", seen, c_gx, locked, video_on);
      end
      step(0);
      checks++;
      if (sync_err !== 1'b0) begin
         errors++;
         $display("FAIL short_pulse sync_err=%b want 0", sync_err);
      end
      vr_cnt = 0;
      for (int i = 0; i < 6 * FCLK && locked !== 1'b1; i++) begin
         clk1();
         if (m_vr) vr_cnt++;
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL relock_trace dut=%h model=%h", act_v, exp_v);
         end
      end
      checks++;
      if (locked !== 1'b1 || vr_cnt != 3) begin
         errors++;
         $display("FAIL relock locked=%b rises=%0d want 1/3", locked, vr_cnt);
      end
   endtask

   task automatic test_sync_loss();
      int e;
      g_kill = 1; drive(); e = 0;
      for (int i = 0; i < 2200; i++) begin
         clk1();
         if (sync_err === 1'b1) e++;
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL loss_trace dut=%h model=%h", act_v, exp_v);
         end
      end
      checks++;
      if (e != 1 || locked !== 1'b0) begin
         errors++;
         $display("FAIL loss_err pulses=%0d locked=%b want 1/0", e, locked);
      end
      g_kill = 0; drive();
      for (int i = 0; i < 8 * FCLK && locked !== 1'b1; i++) begin
         clk1();
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL loss_relock_trace dut=%h model=%h", act_v, exp_v);
         end
      end
      checks++;
      if (locked !== 1'b1) begin
         errors++;
         $display("FAIL loss_relock locked=%b want 1", locked);
      end
   endtask

   task automatic test_pause();
      int tx, e;
      logic [9:0] x0, y0;
      tx = $urandom_range(2, 14);
      for (int i = 0; i < 2 * FCLK; i++) begin
         clk1();
         if (p_tick && c_gx == tx) break;
      end
      x0 = x; y0 = y;
      for (int i = 0; i < 100; i++) begin
         step(0);
         checks++;
         if (x !== x0 || y !== y0 || locked !== 1'b1 || act_v !== exp_v) begin
            errors++;
            $display("FAIL pause_hold x=%0d y=%0d lk=%b want %0d/%0d/1", x, y, locked, x0, y0);
         end
      end
      e = 0;
      for (int i = 0; i < 2 * FCLK; i++) begin
         clk1();
         if (sync_err === 1'b1) e++;
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL pause_trace dut=%h model=%h", act_v, exp_v);
         end
      end
      checks++;
      if (e != 0 || locked !== 1'b1 || h_total !== 10'(HT)) begin
         errors++;
         $display("FAIL pause_resume errs=%0d lk=%b ht=%0d", e, locked, h_total);
      end
   endtask

   task automatic test_reset_mid();
      int tx, ty, vr_cnt;
      tx = $urandom_range(0, HMAX);
      ty = $urandom_range(1, 6);
      for (int i = 0; i < 2 * FCLK; i++) begin
         clk1();
         if (p_tick && c_gx == tx && c_gy == ty) break;
      end
      #2 reset = 1;
      #1;
      checks++;
      if (act_v !== 44'd0) begin
         errors++;
         $display("FAIL reset_async dut=%h want=0", act_v);
      end
      for (int i = 0; i < 3; i++) clk1();
      reset = 0;
      vr_cnt = 0;
      for (int i = 0; i < 6 * FCLK && locked !== 1'b1; i++) begin
         clk1();
         if (m_vr) vr_cnt++;
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL rst_relock_trace dut=%h model=%h", act_v, exp_v);
         end
      end
      checks++;
      if (locked !== 1'b1 || vr_cnt != 3) begin
         errors++;
         $display("FAIL rst_relock locked=%b rises=%0d want 1/3", locked, vr_cnt);
      end
   endtask

   initial begin
      model_reset();
      drive();
      test_reset();
      test_lock();
      test_align();
      test_short_line();
      test_sync_loss();
      test_pause();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
